// File: rtl/fifo_pkg.sv
// Shared types for the FIFO family: full-behaviour selection used by the
// FIFO core and by any wrapper that instantiates it.
package fifo_pkg;

    typedef enum logic {
        FULL_DROP,
        FULL_OVERWRITE
    } full_mode_t;

endpackage

// File: rtl/fifo_pointer.sv
// Wrapping FIFO pointer: synchronous reset, synchronous clear (flush) and
// single-step increment. Wraps naturally at 2**WIDTH.
module fifo_pointer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_incr,
    output logic [WIDTH-1:0] o_ptr
);

    logic [WIDTH-1:0] r_ptr;

    // Pointer register: reset and clear both return to zero, clear beats increment.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_ptr <= '0;
        end else if (i_incr) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/threshold_fifo.sv
// Single-clock show-ahead FIFO with selectable full behaviour (drop-new or
// overwrite-oldest), programmable almost-full/almost-empty thresholds,
// synchronous flush, sticky overflow/underflow flags and a high-water mark.
module threshold_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned DATA_ENTRIES       = 256,
    parameter full_mode_t  FULL_MODE          = FULL_DROP,
    parameter int unsigned ALMOST_FULL_LEVEL  = DATA_ENTRIES - 1,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 1,
    localparam int unsigned AW                = $clog2(DATA_ENTRIES),
    localparam int unsigned CW                = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic                  flush,
    input  logic                  clear_errors,
    output logic [DATA_WIDTH-1:0] data_output,
    output logic [CW-1:0]         num_entries,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CW-1:0]         high_water
);

    if (DATA_ENTRIES < 2 || (DATA_ENTRIES & (DATA_ENTRIES - 1)) != 0) begin : g_bad_depth
        $error("threshold_fifo: DATA_ENTRIES must be a power of 2 and at least 2");
    end
    if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DATA_ENTRIES) begin : g_bad_af
        $error("threshold_fifo: ALMOST_FULL_LEVEL must be in 1..DATA_ENTRIES");
    end
    if (ALMOST_EMPTY_LEVEL > DATA_ENTRIES - 1) begin : g_bad_ae
        $error("threshold_fifo: ALMOST_EMPTY_LEVEL must be in 0..DATA_ENTRIES-1");
    end

    logic [DATA_WIDTH-1:0] r_mem [DATA_ENTRIES];
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [CW-1:0]         r_high_water;

    logic [AW-1:0]         w_wptr;
    logic [AW-1:0]         w_rptr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_write;
    logic                  w_rd_inc;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [CW-1:0]         w_count_nxt;

    assign w_full  = (r_count == CW'(DATA_ENTRIES));
    assign w_empty = (r_count == '0);

    // Operation decode. The read pointer also advances on an overwrite of a
    // full FIFO, so w_rd_inc is "head moves" rather than "a read was honoured".
    always_comb begin
        w_do_write  = 1'b0;
        w_rd_inc    = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            w_do_write = write_enable &&
                         (!w_full || read_enable || (FULL_MODE == FULL_OVERWRITE));
            w_rd_inc   = (read_enable && !w_empty) ||
                         (write_enable && !read_enable && w_full &&
                          (FULL_MODE == FULL_OVERWRITE));
            w_ovf_set  = write_enable && !read_enable && w_full;
            w_unf_set  = read_enable && w_empty;
            if (w_do_write && !w_rd_inc) begin
                w_count_nxt = r_count + 1'b1;
            end else if (w_rd_inc && !w_do_write) begin
                w_count_nxt = r_count - 1'b1;
            end
        end
    end

    fifo_pointer #(.WIDTH(AW)) u_wr_ptr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (flush),
        .i_incr  (w_do_write),
        .o_ptr   (w_wptr)
    );

    fifo_pointer #(.WIDTH(AW)) u_rd_ptr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (flush),
        .i_incr  (w_rd_inc),
        .o_ptr   (w_rptr)
    );

    // Storage write; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && w_do_write) begin
            r_mem[w_wptr] <= data_input;
        end
    end

    // Occupancy, sticky error flags and high-water mark; a same-cycle error wins over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_high_water <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_overflow  <= w_ovf_set | (r_overflow & ~clear_errors);
            r_underflow <= w_unf_set | (r_underflow & ~clear_errors);
            if (clear_errors || (w_count_nxt > r_high_water)) begin
                r_high_water <= w_count_nxt;
            end
        end
    end

    assign data_output  = r_mem[w_rptr];
    assign num_entries  = r_count;
    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign almost_full  = (r_count >= CW'(ALMOST_FULL_LEVEL));
    assign almost_empty = (r_count <= CW'(ALMOST_EMPTY_LEVEL));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign high_water   = r_high_water;

endmodule

// File: tb/tb_threshold_fifo.sv
// Bench for threshold_fifo: one drop-mode and one overwrite-mode instance
// share stimulus; directed vector table, hand sequences, then random
// traffic against a queue-based reference model.
module tb_threshold_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int AEL   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       we, re, fl, ce;

    logic [7:0] d_dout, o_dout;
    logic [2:0] d_cnt, o_cnt, d_hw, o_hw;
    logic       d_full, d_empty, d_af, d_ae, d_ovf, d_unf;
    logic       o_full, o_empty, o_af, o_ae, o_ovf, o_unf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    threshold_fifo #(
        .DATA_WIDTH(8), .DATA_ENTRIES(DEPTH), .FULL_MODE(FULL_DROP),
        .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
    ) u_drop (
        .clk(clk), .reset(reset), .data_input(din), .write_enable(we),
        .read_enable(re), .flush(fl), .clear_errors(ce),
        .data_output(d_dout), .num_entries(d_cnt), .fifo_full(d_full),
        .fifo_empty(d_empty), .almost_full(d_af), .almost_empty(d_ae),
        .overflow(d_ovf), .underflow(d_unf), .high_water(d_hw)
    );

    threshold_fifo #(
        .DATA_WIDTH(8), .DATA_ENTRIES(DEPTH), .FULL_MODE(FULL_OVERWRITE),
        .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
    ) u_ovr (
        .clk(clk), .reset(reset), .data_input(din), .write_enable(we),
        .read_enable(re), .flush(fl), .clear_errors(ce),
        .data_output(o_dout), .num_entries(o_cnt), .fifo_full(o_full),
        .fifo_empty(o_empty), .almost_full(o_af), .almost_empty(o_ae),
        .overflow(o_ovf), .underflow(o_unf), .high_water(o_hw)
    );

    typedef struct {
        logic       we, re, fl, ce;
        logic [7:0] din;
        int         cnt;
        logic       dv;
        logic [7:0] dout;
        logic       ovf, unf;
        int         hw;
    } vec_t;

    vec_t vecs[$];

    // reference model state, index 0 = drop, 1 = overwrite
    logic [7:0] mq [2][$];
    logic       m_ovf [2];
    logic       m_unf [2];
    int         m_hw  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_dut(input string nm, input int sel, input int cnt, input logic dv,
                             input logic [7:0] dd, input logic ovf, input logic unf,
                             input int hw);
        string p;
        p = (sel == 0) ? {nm, "/drop"} : {nm, "/ovr"};
        if (sel == 0) begin
            chk({p, "/count"}, 32'(d_cnt), cnt);
            chk({p, "/full"}, 32'(d_full), 32'(cnt == DEPTH));
            chk({p, "/empty"}, 32'(d_empty), 32'(cnt == 0));
            chk({p, "/afull"}, 32'(d_af), 32'(cnt >= AFL));
            chk({p, "/aempty"}, 32'(d_ae), 32'(cnt <= AEL));
            chk({p, "/ovf"}, 32'(d_ovf), 32'(ovf));
            chk({p, "/unf"}, 32'(d_unf), 32'(unf));
            chk({p, "/hw"}, 32'(d_hw), hw);
            if (dv) chk({p, "/dout"}, 32'(d_dout), 32'(dd));
        end else begin
            chk({p, "/count"}, 32'(o_cnt), cnt);
            chk({p, "/full"}, 32'(o_full), 32'(cnt == DEPTH));
            chk({p, "/empty"}, 32'(o_empty), 32'(cnt == 0));
            chk({p, "/afull"}, 32'(o_af), 32'(cnt >= AFL));
            chk({p, "/aempty"}, 32'(o_ae), 32'(cnt <= AEL));
            chk({p, "/ovf"}, 32'(o_ovf), 32'(ovf));
            chk({p, "/unf"}, 32'(o_unf), 32'(unf));
            chk({p, "/hw"}, 32'(o_hw), hw);
            if (dv) chk({p, "/dout"}, 32'(o_dout), 32'(dd));
        end
    endtask

    task automatic step(input logic s_we, input logic s_re, input logic s_fl,
                        input logic s_ce, input logic [7:0] s_din);
        we = s_we; re = s_re; fl = s_fl; ce = s_ce; din = s_din;
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0; fl = 1'b0; ce = 1'b0;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            m_ovf[m] = 1'b0;
            m_unf[m] = 1'b0;
            m_hw[m]  = 0;
        end
    endtask

    // One clock of the behavioural rules, applied before the edge.
    task automatic model_step(input logic s_we, input logic s_re, input logic s_fl,
                              input logic s_ce, input logic [7:0] s_din);
        for (int m = 0; m < 2; m++) begin
            logic is_full, is_empty, os, us;
            is_full  = (mq[m].size() == DEPTH);
            is_empty = (mq[m].size() == 0);
            os = 1'b0;
            us = 1'b0;
            if (s_fl) begin
                mq[m].delete();
            end else begin
                os = s_we && !s_re && is_full;
                us = s_re && is_empty;
                if (s_re && !is_empty) void'(mq[m].pop_front());
                if (s_we) begin
                    if (is_full && !s_re) begin
                        if (m == 1) begin
                            void'(mq[m].pop_front());
                            mq[m].push_back(s_din);
                        end
                    end else begin
                        mq[m].push_back(s_din);
                    end
                end
            end
            m_ovf[m] = os | (m_ovf[m] & ~s_ce);
            m_unf[m] = us | (m_unf[m] & ~s_ce);
            if (s_ce || mq[m].size() > m_hw[m]) m_hw[m] = mq[m].size();
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; re = 1'b0; fl = 1'b0; ce = 1'b0; din = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) check_dut("reset", s, 0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        reset = 1'b0;

        //            we re fl ce din     cnt dv dout   ovf unf hw
        vecs.push_back('{1, 0, 0, 0, 8'h11, 1, 1, 8'h11, 0, 0, 1});
        vecs.push_back('{1, 0, 0, 0, 8'h22, 2, 1, 8'h11, 0, 0, 2});
        vecs.push_back('{1, 0, 0, 0, 8'h33, 3, 1, 8'h11, 0, 0, 3});
        vecs.push_back('{1, 0, 0, 0, 8'h44, 4, 1, 8'h11, 0, 0, 4});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 3, 1, 8'h22, 0, 0, 4});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 2, 1, 8'h33, 0, 0, 4});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 1, 1, 8'h44, 0, 0, 4});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 4});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 4});
        vecs.push_back('{1, 1, 0, 0, 8'h5A, 1, 1, 8'h5A, 0, 1, 4});
        vecs.push_back('{0, 0, 0, 1, 8'h00, 1, 1, 8'h5A, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1});
        vecs.push_back('{1, 0, 0, 0, 8'h01, 1, 1, 8'h01, 0, 0, 1});
        vecs.push_back('{1, 0, 0, 0, 8'h02, 2, 1, 8'h01, 0, 0, 2});
        vecs.push_back('{1, 0, 0, 0, 8'h03, 3, 1, 8'h01, 0, 0, 3});
        vecs.push_back('{1, 0, 0, 0, 8'h04, 4, 1, 8'h01, 0, 0, 4});
        vecs.push_back('{1, 1, 0, 0, 8'h77, 4, 1, 8'h02, 0, 0, 4});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 3, 1, 8'h03, 0, 0, 4});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 2, 1, 8'h04, 0, 0, 4});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 1, 1, 8'h77, 0, 0, 4});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 4});
        vecs.push_back('{0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 8'hB1, 1, 1, 8'hB1, 0, 0, 1});
        vecs.push_back('{1, 0, 0, 0, 8'hB2, 2, 1, 8'hB1, 0, 0, 2});
        vecs.push_back('{1, 0, 0, 0, 8'hB3, 3, 1, 8'hB1, 0, 0, 3});
        vecs.push_back('{1, 0, 1, 0, 8'hC0, 0, 0, 8'h00, 0, 0, 3});
        vecs.push_back('{1, 0, 0, 0, 8'hD0, 1, 1, 8'hD0, 0, 0, 3});
        vecs.push_back('{0, 1, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0});

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].re, vecs[i].fl, vecs[i].ce, vecs[i].din);
            for (int s = 0; s < 2; s++)
                check_dut($sformatf("vec%0d", i), s, vecs[i].cnt, vecs[i].dv,
                          vecs[i].dout, vecs[i].ovf, vecs[i].unf, vecs[i].hw);
        end

        // write into a full FIFO: drop keeps A0..A3, overwrite keeps A1..A3,FF
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'hA0 + 8'(i));
        step(1, 0, 0, 0, 8'hFF);
        check_dut("full_wr", 0, 4, 1'b1, 8'hA0, 1'b1, 1'b0, 4);
        check_dut("full_wr", 1, 4, 1'b1, 8'hA1, 1'b1, 1'b0, 4);
        begin
            logic [7:0] exp_ovr [4];
            exp_ovr[0] = 8'hA1; exp_ovr[1] = 8'hA2; exp_ovr[2] = 8'hA3; exp_ovr[3] = 8'hFF;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ovf_rd%0d/drop", i), 32'(d_dout), 32'(8'hA0 + 8'(i)));
                chk($sformatf("ovf_rd%0d/ovr", i), 32'(o_dout), 32'(exp_ovr[i]));
                step(0, 1, 0, 0, 8'h00);
            end
        end
        for (int s = 0; s < 2; s++) check_dut("ovf_drain", s, 0, 1'b0, 8'h00, 1'b1, 1'b0, 4);

        // alternating single write/read across several pointer wraps
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 8'h60 + 8'(i));
            for (int s = 0; s < 2; s++)
                check_dut($sformatf("wrap_w%0d", i), s, 1, 1'b1, 8'h60 + 8'(i), 1'b1, 1'b0, 4);
            step(0, 1, 0, 0, 8'h00);
            chk($sformatf("wrap_r%0d/cnt", i), 32'(d_cnt), 0);
        end

        // reset mid-stream with a concurrent write and sticky flags set
        step(0, 1, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h90 + 8'(i));
        for (int s = 0; s < 2; s++) check_dut("pre_rst", s, 3, 1'b1, 8'h90, 1'b0, 1'b1, 3);
        reset = 1'b1;
        step(1, 0, 0, 0, 8'hEE);
        for (int s = 0; s < 2; s++) check_dut("mid_rst", s, 0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        reset = 1'b0;
        model_reset();

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic r_we, r_re, r_fl, r_ce;
            logic [7:0] r_din;
            r_we  = ($urandom % 100) < 55;
            r_re  = ($urandom % 100) < 45;
            r_fl  = ($urandom % 60) == 0;
            r_ce  = !r_fl && (($urandom % 40) == 0);
            r_din = 8'($urandom);
            model_step(r_we, r_re, r_fl, r_ce, r_din);
            step(r_we, r_re, r_fl, r_ce, r_din);
            for (int m = 0; m < 2; m++)
                check_dut($sformatf("rnd%0d", i), m, mq[m].size(), mq[m].size() != 0,
                          (mq[m].size() != 0) ? mq[m][0] : 8'h00,
                          m_ovf[m], m_unf[m], m_hw[m]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
